seq_gen: RTL and testbench

Serial pattern generator: loads a programmable bit pattern and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times. It is the transmit-side counterpart of the team's overlapping serial sequence detector and drives that detector's `seq_in` in system tests and in the bring-up datapath. An optional idle gap can be inserted between repetitions.

---
 rtl/seq_gen_pkg.sv | 12 +
 rtl/seq_gen_shreg.sv | 41 ++++
 rtl/seq_gen.sv | 130 +++++++++++++
 tb/tb_seq_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern generator: FSM encoding and parameter defaults.
package seq_gen_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/seq_gen_shreg.sv
// Pattern register and MSB-first bit index for seq_gen; the index wraps to the latched
// length after bit 0 so back-to-back repetitions need no extra load cycle.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     step,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [$clog2(PAT_W)-1:0] len_m1,
    output logic                     cur_bit,
    output logic                     last_bit
);

    localparam int IDX_W = $clog2(PAT_W);

    logic [PAT_W-1:0] pat_q;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            len_q <= '0;
            idx   <= '0;
        end else if (load) begin
            pat_q <= pattern;
            len_q <= len_m1;
            idx   <= len_m1;
        end else if (step) begin
            idx <= (idx == '0) ? len_q : idx - IDX_W'(1);
        end
    end

    assign cur_bit  = pat_q[idx];
    assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, repeated rep_m1+1 times.
// Define SEQ_GEN_GAP_EN to add the gap_len port and idle cycles between repetitions.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [$clog2(PAT_W)-1:0] len_m1,
    input  logic [CNT_W-1:0]         rep_m1,
`ifdef SEQ_GEN_GAP_EN
    input  logic [3:0]               gap_len,
`endif
    output logic                     seq_out,
    output logic                     seq_valid,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_out
);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] rep_q;
    logic             load;
    logic             step;
    logic             cur_bit;
    logic             last_bit;
`ifdef SEQ_GEN_GAP_EN
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt;
`endif

    assign load = (state == IDLE) && start;
    assign step = (state == SHIFT);

    seq_gen_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .pattern  (pattern),
        .len_m1   (len_m1),
        .cur_bit  (cur_bit),
        .last_bit (last_bit)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (rep_q == '0) begin
                        state_nx = FINISH;
`ifdef SEQ_GEN_GAP_EN
                    end else if (gap_q != 4'd0) begin
                        state_nx = GAP;
`endif
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            // gap_cnt is loaded with gap_q on entry, so GAP lasts exactly gap_q cycles
            GAP:    if (gap_cnt <= 4'd1) state_nx = SHIFT;
`else
            GAP:    state_nx = IDLE;
`endif
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rep_q <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                rep_q <= rep_m1;
            end else if (step && last_bit && rep_q != '0) begin
                rep_q <= rep_q - CNT_W'(1);
            end
        end
    end

`ifdef SEQ_GEN_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            if (load) begin
                gap_q <= gap_len;
            end
            if (state == SHIFT && state_nx == GAP) begin
                gap_cnt <= gap_q;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
`endif

    // Outputs are registered decodes of the current state, one cycle behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            seq_out   <= (state == SHIFT) && cur_bit;
            seq_valid <= (state == SHIFT);
            busy      <= (state != IDLE);
            done      <= (state == FINISH);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: every busy cycle is checked against hand-written
// expected strings ('1'/'0' valid bit, 'g' gap cycle, 'd' done pulse).
`timescale 1ns/1ps
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [2:0] len_m1 = '0;
    logic [3:0] rep_m1 = '0;
`ifdef SEQ_GEN_GAP_EN
    logic [3:0] gap_len = '0;
`endif
    logic       seq_out;
    logic       seq_valid;
    logic       busy;
    logic       done;
    logic [1:0] state_out;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    seq_gen #(
        .PAT_W (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .len_m1    (len_m1),
        .rep_m1    (rep_m1),
`ifdef SEQ_GEN_GAP_EN
        .gap_len   (gap_len),
`endif
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every busy cycle must match the next expected {valid,out,done} token
    always @(negedge clk) begin
        if (mon_en && rst_n && busy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_busy: got valid=%0d out=%0d done=%0d expected no activity",
                         seq_valid, seq_out, done);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("stream", int'({seq_valid, seq_out, done}), int'(e));
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "1":     exp_q.push_back(3'b110);
                "0":     exp_q.push_back(3'b100);
                "g":     exp_q.push_back(3'b000);
                default: exp_q.push_back(3'b001);
            endcase
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL %s_timeout: got %0d tokens left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check({name, "_done_seen"}, int'(done), 1);
    endtask

    task automatic count_busy(output int cnt);
        int n;
        cnt = 0;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        int bits;

        // reset state
        #12;
        check("rst_seq_out", int'(seq_out), 0);
        check("rst_seq_valid", int'(seq_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(state_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 3-bit pattern 101 repeated twice
        pattern = 8'h05; len_m1 = 3'd2; rep_m1 = 4'd1;
        push_str("101101d");
        pulse_start();
        drain("pat05");

        // full-width pattern, latched inputs, start ignored while shifting
        pattern = 8'hA5; len_m1 = 3'd7; rep_m1 = 4'd0;
        push_str("10100101d");
        pulse_start();
        fork
            count_busy(nb);
            begin
                repeat (3) @(posedge clk);
                #1 pattern = 8'h5A; len_m1 = 3'd3; rep_m1 = 4'd5; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        check("busy_cycles", nb, 9);
        drain("patA5");
        repeat (5) @(negedge clk);
        check("start_in_shift_ignored", int'(busy), 0);

        // start held high: back-to-back streams with one IDLE cycle between
        pattern = 8'h05; len_m1 = 3'd2; rep_m1 = 4'd0;
        push_str("101d101d");
        @(posedge clk); #1 start = 1'b1;
        wait_done("held1");
        @(negedge clk);
        check("idle_gap_busy", int'(busy), 0);
        check("idle_gap_valid", int'(seq_valid), 0);
        @(negedge clk);
        check("restart_valid", int'(seq_valid), 1);
        wait_done("held2");
        start = 1'b0;
        drain("held");
        repeat (4) @(negedge clk);
        check("held_no_third", int'(busy), 0);

`ifdef SEQ_GEN_GAP_EN
        // idle gap between repetitions
        pattern = 8'h02; len_m1 = 3'd1; rep_m1 = 4'd2; gap_len = 4'd3;
        push_str("10ggg10ggg10d");
        pulse_start();
        drain("gap");
        gap_len = 4'd0;
`endif

        // asynchronous reset during bit 3 of 8
        mon_en = 1'b0;
        pattern = 8'hA5; len_m1 = 3'd7; rep_m1 = 4'd0;
        pulse_start();
        bits = 0;
        nb = 0;
        while (bits < 3 && nb < 20) begin
            @(negedge clk);
            if (seq_valid) bits++;
            nb++;
        end
        check("bit3_reached", bits, 3);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_seq_out", int'(seq_out), 0);
        check("midrst_seq_valid", int'(seq_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_state", int'(state_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) nb++;
        end
        check("midrst_no_done", nb, 0);
        check("midrst_idle", int'(state_out), 0);
        mon_en = 1'b1;
        push_str("10100101d");
        pulse_start();
        drain("after_rst");

        // 1-bit pattern, maximum repeat count
        pattern = 8'h01; len_m1 = 3'd0; rep_m1 = 4'd15;
        push_str("1111111111111111d");
        pulse_start();
        drain("len1_rep16");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
